// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers one CPU request at a time with a fixed
// LATENCY-cycle wait, byte-enabled writes and an error response for bad addresses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        stall,
  output logic        err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  logic [3:0]  wait_cnt;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] rdata_q;
  logic        err_q;

  logic             accept;
  logic             enter_resp;
  logic             t_wr;
  logic [31:0]      t_addr;
  logic [31:0]      t_wdata;
  logic [3:0]       t_be;
  logic             t_bad;
  logic [IDX_W-1:0] t_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (LATENCY > 0) ? BUSY : RESP;
      BUSY:    if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && req;
  assign enter_resp = (state_nxt == RESP);

  // With zero latency the transaction completes on its acceptance edge, so the
  // live request fields stand in for the not-yet-latched copies.
  always_comb begin
    t_wr    = lat_wr;
    t_addr  = lat_addr;
    t_wdata = lat_wdata;
    t_be    = lat_be;
    if (state == IDLE) begin
      t_wr    = wr;
      t_addr  = addr;
      t_wdata = wdata;
      t_be    = be;
    end
  end

  assign t_bad = (t_addr[1:0] != 2'b00) || ({2'b00, t_addr[31:2]} >= DEPTH_L);
  assign t_idx = t_addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_wr    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_wr    <= wr;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_be    <= be;
        wait_cnt  <= WAIT_LOAD;
      end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q <= t_bad;
        if (t_bad) begin
          rdata_q <= 32'd0;
        end else if (!t_wr) begin
          rdata_q <= mem[t_idx];
        end
      end
    end
  end

  // Array is intentionally never reset; reset only aborts the in-flight request.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && t_wr && !t_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (t_be[i]) mem[t_idx][8*i +: 8] <= t_wdata[8*i +: 8];
      end
    end
  end

  assign ack   = !rst && (state == RESP);
  assign err   = ack && err_q;
  assign rdata = rst ? 32'd0 : rdata_q;
  assign stall = !rst && (((state == IDLE) && req) || (state == BUSY));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=0,
// each checked against a word-level memory model held in an associative array.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic        req_v   [2];
  logic        wr_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  be_v    [2];
  logic [31:0] rdata_v [2];
  logic        ack_v   [2];
  logic        stall_v [2];
  logic        err_v   [2];

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [longint];

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .wr(wr_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .be(be_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]),
    .stall(stall_v[0]), .err(err_v[0]));

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .wr(wr_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .be(be_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]),
    .stall(stall_v[1]), .err(err_v[1]));

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic longint key(input int d, input logic [31:0] a);
    return longint'(d) * 64'h1_0000_0000 + longint'(a[31:2]);
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Model update for a write the memory should accept.
  task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] b);
    longint k;
    k = key(d, a);
    if (!bad_addr(a)) mdl[k] = merge(mdl.exists(k) ? mdl[k] : 32'd0, wd, b);
  endtask

  // Drives one request on instance d from a falling edge and holds it until ack
  // (or drops/scrambles it at cycle drop_at). Returns at the falling edge after ack.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input int drop_at, output logic got,
                     output int acyc, output int stalls, output logic [31:0] rd,
                     output logic er);
    got = 1'b0; acyc = -1; stalls = 0; rd = 32'd0; er = 1'b0;
    req_v[d] = 1'b1; wr_v[d] = w; addr_v[d] = a; wdata_v[d] = wd; be_v[d] = b;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      #1;
      if (stall_v[d]) stalls++;
      if (ack_v[d]) begin
        got = 1'b1; acyc = cyc; rd = rdata_v[d]; er = err_v[d];
        req_v[d] = 1'b0;
      end else if (cyc == drop_at) begin
        req_v[d] = 1'b0; wr_v[d] = ~w; addr_v[d] = $urandom;
        wdata_v[d] = $urandom; be_v[d] = 4'($urandom);
      end
      @(negedge clk);
    end
    req_v[d] = 1'b0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin rst_v[d] = 1'b1; req_v[d] = 1'b1; end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (ack_v[d] !== 1'b0 || err_v[d] !== 1'b0 || rdata_v[d] !== 32'd0 || stall_v[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: ack=%b err=%b rdata=%h stall=%b, required 0 0 00000000 0",
                 d, ack_v[d], err_v[d], rdata_v[d], stall_v[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin rst_v[d] = 1'b0; req_v[d] = 1'b0; end
    @(negedge clk);
  endtask

  task automatic init_mem;
    logic g, e; int ac, st; logic [31:0] rd, wd;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 24; i++) begin
        wd = $urandom;
        txn(d, 1'b1, 32'(i * 4), wd, 4'hF, -1, g, ac, st, rd, e);
        mdl_write(d, 32'(i * 4), wd, 4'hF);
      end
    end
  endtask

  task automatic test_basic;
    logic g, e; int ac, st; logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 32'h54, 32'd7, 4'hF, -1, g, ac, st, rd, e);
      mdl_write(d, 32'h54, 32'd7, 4'hF);
      tests++;
      if (g !== 1'b1 || ac != lat(d) + 1 || st != lat(d) + 1 || e !== 1'b0) begin
        fails++;
        $display("FAIL write84[%0d]: got=%b ack_cyc=%0d stalls=%0d err=%b, required 1 %0d %0d 0",
                 d, g, ac, st, e, lat(d) + 1, lat(d) + 1);
      end
      #1;
      tests++;
      if (ack_v[d] !== 1'b0) begin
        fails++;
        $display("FAIL ack_pulse[%0d]: ack=%b after response, required 0", d, ack_v[d]);
      end
      @(negedge clk);
      txn(d, 1'b0, 32'h54, 32'h0, 4'h0, -1, g, ac, st, rd, e);
      tests++;
      if (g !== 1'b1 || ac != lat(d) + 1 || st != lat(d) + 1 || rd !== 32'd7 || e !== 1'b0) begin
        fails++;
        $display("FAIL read84[%0d]: got=%b ack_cyc=%0d stalls=%0d rdata=%h err=%b, required 1 %0d %0d 00000007 0",
                 d, g, ac, st, rd, e, lat(d) + 1, lat(d) + 1);
      end
      #1;
      tests++;
      if (rdata_v[d] !== 32'd7) begin
        fails++;
        $display("FAIL rdata_hold[%0d]: rdata=%h outside ack, required 00000007", d, rdata_v[d]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_byte_enables;
    logic g, e; int ac, st; logic [31:0] rd;
    txn(0, 1'b1, 32'h50, 32'h11223344, 4'hF, -1, g, ac, st, rd, e);
    txn(0, 1'b1, 32'h50, 32'hAABBCCDD, 4'h1, -1, g, ac, st, rd, e);
    txn(0, 1'b0, 32'h50, 32'h0, 4'h0, -1, g, ac, st, rd, e);
    tests++;
    if (rd !== 32'h112233DD || e !== 1'b0) begin
      fails++;
      $display("FAIL be0001: rdata=%h err=%b, required 112233dd 0", rd, e);
    end
    txn(0, 1'b1, 32'h50, 32'h55667788, 4'h0, -1, g, ac, st, rd, e);
    tests++;
    if (g !== 1'b1 || e !== 1'b0) begin
      fails++;
      $display("FAIL be0000_ack: got=%b err=%b, required 1 0", g, e);
    end
    txn(0, 1'b0, 32'h50, 32'h0, 4'hF, -1, g, ac, st, rd, e);
    tests++;
    if (rd !== 32'h112233DD) begin
      fails++;
      $display("FAIL be0000: rdata=%h, required 112233dd", rd);
    end
    mdl_write(0, 32'h50, 32'h112233DD, 4'hF);
  endtask

  task automatic test_errors;
    logic g, e; int ac, st; logic [31:0] rd;
    txn(0, 1'b0, 32'h54, 32'h0, 4'h0, -1, g, ac, st, rd, e);
    txn(0, 1'b0, 32'h52, 32'h0, 4'hF, -1, g, ac, st, rd, e);
    tests++;
    if (g !== 1'b1 || ac != 3 || e !== 1'b1 || rd !== 32'd0) begin
      fails++;
      $display("FAIL misaligned: got=%b ack_cyc=%0d err=%b rdata=%h, required 1 3 1 00000000", g, ac, e, rd);
    end
    #1;
    tests++;
    if (err_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL err_idle: err=%b without ack, required 0", err_v[0]);
    end
    @(negedge clk);
    txn(0, 1'b1, 32'd1024, 32'hCAFEF00D, 4'hF, -1, g, ac, st, rd, e);
    tests++;
    if (g !== 1'b1 || e !== 1'b1) begin
      fails++;
      $display("FAIL range_wr: got=%b err=%b, required 1 1", g, e);
    end
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, -1, g, ac, st, rd, e);
    tests++;
    if (rd !== mdl[key(0, 32'h0)] || e !== 1'b0) begin
      fails++;
      $display("FAIL word0_kept: rdata=%h err=%b, required %h 0", rd, e, mdl[key(0, 32'h0)]);
    end
  endtask

  task automatic test_rst_abort;
    logic g, e; int ac, st, acks; logic [31:0] rd;
    txn(0, 1'b0, 32'h58, 32'h0, 4'h0, -1, g, ac, st, rd, e);
    req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 32'h58; wdata_v[0] = 32'hDEADBEEF; be_v[0] = 4'hF;
    @(negedge clk);
    #1;
    tests++;
    if (stall_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL busy_stall: stall=%b in wait state, required 1", stall_v[0]);
    end
    rst_v[0] = 1'b1;
    #1;
    tests++;
    if (stall_v[0] !== 1'b0 || ack_v[0] !== 1'b0 || err_v[0] !== 1'b0 || rdata_v[0] !== 32'd0) begin
      fails++;
      $display("FAIL rst_busy: stall=%b ack=%b err=%b rdata=%h, required 0 0 0 00000000",
               stall_v[0], ack_v[0], err_v[0], rdata_v[0]);
    end
    @(negedge clk);
    rst_v[0] = 1'b0; req_v[0] = 1'b0;
    acks = 0;
    repeat (8) begin #1; if (ack_v[0]) acks++; @(negedge clk); end
    tests++;
    if (acks != 0) begin
      fails++;
      $display("FAIL abort_noack: %0d acks after reset abort, required 0", acks);
    end
    txn(0, 1'b0, 32'h58, 32'h0, 4'h0, -1, g, ac, st, rd, e);
    tests++;
    if (rd !== mdl[key(0, 32'h58)]) begin
      fails++;
      $display("FAIL abort_nowrite: rdata=%h, required %h", rd, mdl[key(0, 32'h58)]);
    end
    // Reset arriving in the response cycle must suppress that ack.
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 32'h54;
    @(negedge clk); req_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (ack_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL resp_ack: ack=%b before reset, required 1", ack_v[0]);
    end
    rst_v[0] = 1'b1;
    #1;
    tests++;
    if (ack_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_resp: ack=%b during reset, required 0", ack_v[0]);
    end
    @(negedge clk);
    rst_v[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop_req;
    logic g, e; int ac, st; logic [31:0] rd;
    txn(0, 1'b0, 32'h54, 32'h0, 4'h0, 1, g, ac, st, rd, e);
    tests++;
    if (g !== 1'b1 || ac != 3 || rd !== 32'd7 || e !== 1'b0) begin
      fails++;
      $display("FAIL drop_req: got=%b ack_cyc=%0d rdata=%h err=%b, required 1 3 00000007 0", g, ac, rd, e);
    end
  endtask

  task automatic test_back_to_back;
    int exp_q[$];
    int got_q[$];
    int bad;
    for (int d = 0; d < 2; d++) begin
      exp_q.delete(); got_q.delete(); bad = 0;
      for (int p = lat(d) + 1; p < 16; p += lat(d) + 2) exp_q.push_back(p);
      req_v[d] = 1'b1; wr_v[d] = 1'b0; addr_v[d] = 32'h54; be_v[d] = 4'h0;
      for (int cyc = 0; cyc < 16; cyc++) begin
        #1;
        if (ack_v[d]) begin
          got_q.push_back(cyc);
          if (rdata_v[d] !== 32'd7 || err_v[d] !== 1'b0) bad++;
        end
        @(negedge clk);
      end
      req_v[d] = 1'b0;
      repeat (6) @(negedge clk);
      tests++;
      if (got_q != exp_q || bad != 0) begin
        fails++;
        $display("FAIL b2b[%0d]: ack cycles %p (%0d bad data), required %p", d, got_q, bad, exp_q);
      end
    end
  endtask

  task automatic test_random;
    logic g, e, w, eerr; int ac, st, kind, drop; logic [31:0] rd, a, wd, erd; logic [3:0] b;
    longint k;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        w    = 1'($urandom_range(0, 1));
        kind = $urandom_range(0, 9);
        if (kind < 7)       a = 32'($urandom_range(0, 23) * 4);
        else if (kind == 7) a = 32'($urandom_range(0, 23) * 4 + $urandom_range(1, 3));
        else                a = 32'(($urandom_range(256, 5000)) * 4);
        wd   = $urandom;
        b    = 4'($urandom);
        drop = $urandom_range(0, 1) ? 1 : -1;
        eerr = bad_addr(a);
        k    = key(d, a);
        erd  = eerr ? 32'd0 : (mdl.exists(k) ? mdl[k] : 32'd0);
        txn(d, w, a, wd, b, drop, g, ac, st, rd, e);
        tests++;
        if (g !== 1'b1 || ac != lat(d) + 1 || st != lat(d) + 1) begin
          fails++;
          $display("FAIL rnd_timing[%0d.%0d]: got=%b ack_cyc=%0d stalls=%0d, required 1 %0d %0d",
                   d, n, g, ac, st, lat(d) + 1, lat(d) + 1);
        end
        tests++;
        if (e !== eerr || (!w && (eerr || mdl.exists(k)) && rd !== erd)) begin
          fails++;
          $display("FAIL rnd_data[%0d.%0d]: wr=%b addr=%h err=%b rdata=%h, required err=%b rdata=%h",
                   d, n, w, a, e, rd, eerr, erd);
        end
        if (w) mdl_write(d, a, wd, b);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; req_v[d] = 1'b0; wr_v[d] = 1'b0;
      addr_v[d] = 32'd0; wdata_v[d] = 32'd0; be_v[d] = 4'd0;
    end
    @(negedge clk);
    test_reset();
    init_mem();
    test_basic();
    test_byte_enables();
    test_errors();
    test_rst_abort();
    test_drop_req();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
